// File: rtl/cfg_pkg.sv
// cfg_pkg: shared definitions for the configuration loader.
//   - header field offsets/widths and kind encodings
//   - FSM state encodings and the state enum
package cfg_pkg;

    // Header byte layout: [7:6] kind, [5:3] block address, [2:0] word index.
    localparam int unsigned KIND_LSB = 6;
    localparam int unsigned ADDR_LSB = 3;
    localparam int unsigned WSEL_LSB = 0;
    localparam int unsigned KIND_W   = 2;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned WSEL_W   = 3;

    localparam logic [KIND_W-1:0] KIND_X  = 2'b00;
    localparam logic [KIND_W-1:0] KIND_Y  = 2'b01;
    localparam logic [KIND_W-1:0] KIND_AB = 2'b10;
    localparam logic [KIND_W-1:0] KIND_CX = 2'b11;

    localparam logic [2:0] ST_HDR    = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    typedef enum logic [2:0] {
        StHdr    = ST_HDR,
        StData   = ST_DATA,
        StSetup  = ST_SETUP,
        StStrobe = ST_STROBE,
        StHold   = ST_HOLD
    } state_t;

endpackage

// File: rtl/cfg_hdr_decode.sv
// cfg_hdr_decode: combinational decode of a latched header byte.
// Ports:
//   hdr      in   8          latched header byte
//   kind_oh  out  4          one-hot kind {cx, ab, y, x}
//   word_oh  out  NUM_WORDS  one-hot word select (all zero when illegal)
//   illegal  out  1          word index >= NUM_WORDS
module cfg_hdr_decode
    import cfg_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic [7:0]           hdr,
    output logic [3:0]           kind_oh,
    output logic [NUM_WORDS-1:0] word_oh,
    output logic                 illegal
);

    logic [KIND_W-1:0] kind;
    logic [WSEL_W-1:0] wsel;

    assign kind = hdr[KIND_LSB +: KIND_W];
    assign wsel = hdr[WSEL_LSB +: WSEL_W];

    always_comb begin
        kind_oh = '0;
        unique case (kind)
            KIND_X:  kind_oh[0] = 1'b1;
            KIND_Y:  kind_oh[1] = 1'b1;
            KIND_AB: kind_oh[2] = 1'b1;
            KIND_CX: kind_oh[3] = 1'b1;
        endcase
    end

    always_comb begin
        illegal = (32'(wsel) >= NUM_WORDS);
        word_oh = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            word_oh[i] = !illegal && (32'(wsel) == i);
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: byte-stream configuration loader. Accepts (header, data) frames over a
// valid/ready byte interface and drives a shared bus plus one set_* strobe per frame,
// framed by a setup cycle and a hold cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/in_valid      host byte stream; in_ready accepts (transfer = valid & ready)
//   abort                 drop partial frame, return to header state
//   clr_err               clear sticky err (a same-cycle new error wins)
//   cfg_in/cfg_addr       data byte and block address to the words
//   set_x/y/ab/cx         one-cycle strobes
//   word_en               one-hot word select
//   busy                  high outside the header state
//   err                   sticky illegal word index flag
//   wr_count              number of strobes issued (wraps)
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 abort,
    input  logic                 clr_err,
    output logic [7:0]           cfg_in,
    output logic [2:0]           cfg_addr,
    output logic                 set_x,
    output logic                 set_y,
    output logic                 set_ab,
    output logic                 set_cx,
    output logic [NUM_WORDS-1:0] word_en,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     wr_count
);

    state_t               state_q, state_d;
    logic [7:0]           hdr_q, hdr_d;
    logic [7:0]           cfg_in_q, cfg_in_d;
    logic [2:0]           cfg_addr_q, cfg_addr_d;
    logic [NUM_WORDS-1:0] word_en_q, word_en_d;
    logic [3:0]           strobe_q, strobe_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [3:0]           kind_oh;
    logic [NUM_WORDS-1:0] word_oh;
    logic                 illegal;
    logic                 xfer;
    logic                 load_bus;

    cfg_hdr_decode #(
        .NUM_WORDS (NUM_WORDS)
    ) u_hdr_decode (
        .hdr     (hdr_q),
        .kind_oh (kind_oh),
        .word_oh (word_oh),
        .illegal (illegal)
    );

    // The ready flop reflects the state; abort must veto a same-cycle transfer so the
    // host keeps its byte, hence the single gate after the flop.
    assign in_ready = rdy_q & ~abort;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHdr: begin
                if (xfer) state_d = StData;
            end
            StData: begin
                if (abort)     state_d = StHdr;
                else if (xfer) state_d = illegal ? StHdr : StSetup;
            end
            StSetup:  state_d = abort ? StHdr : StStrobe;
            // The strobe is already on the wire; abort only skips the hold cycle.
            StStrobe: state_d = abort ? StHdr : StHold;
            StHold:   state_d = StHdr;
            default:  state_d = StHdr;
        endcase
    end

    always_comb begin
        hdr_d      = hdr_q;
        cfg_in_d   = cfg_in_q;
        cfg_addr_d = cfg_addr_q;
        word_en_d  = word_en_q;
        err_d      = err_q;

        if (state_q == StHdr && xfer) hdr_d = in_data;

        // Bus is loaded on the data transfer so it is already valid in SETUP.
        load_bus = (state_q == StData) && xfer && !illegal;
        if (load_bus) begin
            cfg_in_d   = in_data;
            cfg_addr_d = hdr_q[ADDR_LSB +: ADDR_W];
            word_en_d  = word_oh;
        end
        if (abort) word_en_d = '0;

        if (state_q == StData && xfer && illegal) err_d = 1'b1;
        else if (clr_err)                         err_d = 1'b0;

        strobe_d = (state_d == StStrobe) ? kind_oh : 4'b0000;
        cnt_d    = (state_d == StStrobe) ? cnt_q + 1'b1 : cnt_q;
        rdy_d    = (state_d == StHdr) || (state_d == StData);
        busy_d   = (state_d != StHdr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StHdr;
            hdr_q      <= '0;
            cfg_in_q   <= '0;
            cfg_addr_q <= '0;
            word_en_q  <= '0;
            strobe_q   <= '0;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            cfg_in_q   <= cfg_in_d;
            cfg_addr_q <= cfg_addr_d;
            word_en_q  <= word_en_d;
            strobe_q   <= strobe_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cfg_in   = cfg_in_q;
    assign cfg_addr = cfg_addr_q;
    assign word_en  = word_en_q;
    assign set_x    = strobe_q[0];
    assign set_y    = strobe_q[1];
    assign set_ab   = strobe_q[2];
    assign set_cx   = strobe_q[3];
    assign busy     = busy_q;
    assign err      = err_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: scoreboard bench for cfg_loader. Drivers push expected strobes into a
// queue computed from the header fields; a negedge monitor pops and compares.
module tb_cfg_loader;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic        clr_err = 1'b0;
    logic [7:0]  cfg_in;
    logic [2:0]  cfg_addr;
    logic        set_x, set_y, set_ab, set_cx;
    logic [NW-1:0] word_en;
    logic        busy;
    logic        err;
    logic [15:0] wr_count;

    cfg_loader #(.NUM_WORDS(NW), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .abort    (abort),
        .clr_err  (clr_err),
        .cfg_in   (cfg_in),
        .cfg_addr (cfg_addr),
        .set_x    (set_x),
        .set_y    (set_y),
        .set_ab   (set_ab),
        .set_cx   (set_cx),
        .word_en  (word_en),
        .busy     (busy),
        .err      (err),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  strb;
        logic [7:0]  data;
        logic [2:0]  addr;
        logic [3:0]  wen;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   strobe_log[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model state.
    logic [15:0] m_cnt = '0;
    logic        m_err = 1'b0;
    logic [7:0]  m_data = '0;
    logic [2:0]  m_addr = '0;
    logic [3:0]  m_wen = '0;

    logic [7:0]  p_data;
    logic [2:0]  p_addr;
    logic [3:0]  p_wen;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && {set_cx, set_ab, set_y, set_x} != 4'b0000) begin
            strobe_log.push_back(cyc);
            if (sbq.size() == 0) begin
                chk("unexpected_strobe", 32'({set_cx, set_ab, set_y, set_x}), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("strobe_sel", 32'({set_cx, set_ab, set_y, set_x}), 32'(mon_e.strb));
                chk("cfg_in", 32'(cfg_in), 32'(mon_e.data));
                chk("cfg_addr", 32'(cfg_addr), 32'(mon_e.addr));
                chk("word_en", 32'(word_en), 32'(mon_e.wen));
                chk("wr_count", 32'(wr_count), 32'(mon_e.cnt));
                chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("setup_stable", 32'({p_data, p_addr, p_wen}),
                    32'({cfg_in, cfg_addr, word_en}));
                chk("ready_in_strobe", 32'(in_ready), 32'd0);
                chk("busy_in_strobe", 32'(busy), 32'd1);
            end
        end
        p_data <= cfg_in;
        p_addr <= cfg_addr;
        p_wen  <= word_en;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 after the transfer; xc is the cycle in which it happened.
    task automatic send_byte(input logic [7:0] b, input bit keep, output bit ok,
                             output int xc);
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        xc = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                xc = cyc;
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!keep) in_valid = 1'b0;
        if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] data, input bit keep);
        bit   ok;
        int   xc;
        int   kind, addr, w;
        exp_t e;
        send_byte(hdr, keep, ok, xc);
        if (!ok) return;
        send_byte(data, keep, ok, xc);
        if (!ok) return;
        kind = int'(hdr) / 64;
        addr = (int'(hdr) / 8) % 8;
        w    = int'(hdr) % 8;
        if (w < NW) begin
            m_cnt  = m_cnt + 16'd1;
            m_data = data;
            m_addr = 3'(addr);
            m_wen  = 4'(1 << w);
            e.strb = 4'(1 << kind);
            e.data = m_data;
            e.addr = m_addr;
            e.wen  = m_wen;
            e.cnt  = m_cnt;
            e.cyc  = xc + 2;
            sbq.push_back(e);
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic abort_in_data(input logic [7:0] hdr, input logic [7:0] data);
        bit ok;
        int xc;
        send_byte(hdr, 1'b0, ok, xc);
        in_data  = data;
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        chk("abort_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        m_wen    = '0;
    endtask

    task automatic check_bus(string tag);
        chk({tag, "_cfg_in"}, 32'(cfg_in), 32'(m_data));
        chk({tag, "_cfg_addr"}, 32'(cfg_addr), 32'(m_addr));
        chk({tag, "_word_en"}, 32'(word_en), 32'(m_wen));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_strobes"}, 32'({set_cx, set_ab, set_y, set_x}), 32'd0);
        chk({tag, "_word_en"}, 32'(word_en), 32'd0);
        chk({tag, "_cfg_bus"}, 32'({cfg_in, cfg_addr}), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int xc;
        logic [7:0] h, d;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Kind x, addr 1, word 2
        send_frame(8'h0A, 8'h5C, 1'b0);
        idle(6);
        chk("first_count", 32'(wr_count), 32'(m_cnt));
        check_bus("frame1");

        // Highest legal word, then an illegal one, then clear
        send_frame(8'hFB, 8'hA5, 1'b0);
        idle(6);
        check_bus("word3");
        send_frame(8'hFC, 8'h33, 1'b0);
        idle(6);
        check_bus("word4_illegal");
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        m_err = 1'b0;
        chk("clr_err", 32'(err), 32'(m_err));

        // Abort in DATA, then a normal ab frame
        abort_in_data(8'h40, 8'h77);
        idle(3);
        chk("abort_busy", 32'(busy), 32'd0);
        check_bus("after_abort");
        send_frame(8'h80, 8'h11, 1'b0);
        idle(6);
        check_bus("ab_frame");
        chk("sb_empty_directed", 32'(sbq.size()), 32'd0);

        // Three back-to-back frames with in_valid held high
        strobe_log.delete();
        send_frame(8'h09, 8'h01, 1'b1);
        send_frame(8'h50, 8'h02, 1'b1);
        send_frame(8'hD3, 8'h03, 1'b1);
        in_valid = 1'b0;
        idle(6);
        chk("stream_strobes", 32'(strobe_log.size()), 32'd3);
        if (strobe_log.size() == 3) begin
            chk("stream_gap0", 32'(strobe_log[1] - strobe_log[0]), 32'd5);
            chk("stream_gap1", 32'(strobe_log[2] - strobe_log[1]), 32'd5);
        end

        // Reset asserted while a strobe is high
        send_frame(8'h41, 8'h22, 1'b0);
        ok = 1'b0;
        for (int n = 0; n < 8 && !ok; n++) begin
            @(negedge clk);
            if ({set_cx, set_ab, set_y, set_x} != 4'b0000) ok = 1'b1;
        end
        chk("strobe_before_rst", 32'(ok), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_strobe", 32'({set_cx, set_ab, set_y, set_x}), 32'd0);
        sbq.delete();
        m_cnt = '0; m_err = 1'b0; m_data = '0; m_addr = '0; m_wen = '0;
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(8'h0A, 8'h5C, 1'b0);
        idle(6);
        check_bus("post_rst");
        chk("post_rst_count", 32'(wr_count), 32'd1);

        // Counter wrap
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFF;
        idle(2);
        send_frame(8'hC1, 8'h66, 1'b0);
        idle(6);
        chk("wrap_count", 32'(wr_count), 32'd0);

        // clr_err concurrent with a new illegal data transfer
        send_byte(8'h07, 1'b0, ok, xc);
        clr_err = 1'b1;
        send_byte(8'h99, 1'b0, ok, xc);
        clr_err = 1'b0;
        m_err = 1'b1;
        idle(2);
        chk("set_wins", 32'(err), 32'd1);
        check_bus("set_wins");

        // Randomized frames
        for (int i = 0; i < 60; i++) begin
            h = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) abort_in_data(h, d);
            else send_frame(h, d, 1'b0);
            check_bus("rand");
            if ($urandom_range(0, 7) == 0) begin
                clr_err = 1'b1;
                idle(1);
                clr_err = 1'b0;
                m_err = 1'b0;
            end
            idle($urandom_range(0, 3));
        end

        idle(8);
        chk("sb_empty_end", 32'(sbq.size()), 32'd0);
        chk("final_count", 32'(wr_count), 32'(m_cnt));
        chk("final_err", 32'(err), 32'(m_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
